// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the pipeline MEM stage (priority) and a loader port.
// A loader request blocked by the pipeline for STARVE_LIMIT cycles steals one cycle and stalls the pipeline.
module dmem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT  = 4,
   parameter logic [2:0]  LD_LOAD_TYPE  = 3'b010,
   parameter logic [1:0]  LD_STORE_TYPE = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_mem_read,
   input  logic        pipe_mem_write,
   input  logic [2:0]  pipe_load_type,
   input  logic [1:0]  pipe_store_type,
   input  logic [9:0]  pipe_addr,
   input  logic [31:0] pipe_wdata,
   output logic [31:0] pipe_rdata,
   output logic        pipe_stall,
   input  logic        ld_req,
   input  logic        ld_we,
   input  logic [9:0]  ld_addr,
   input  logic [31:0] ld_wdata,
   output logic        ld_gnt,
   output logic        ld_rvalid,
   output logic [31:0] ld_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_load_type,
   output logic [1:0]  mem_store_type,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        state_dbg
);

   localparam int unsigned CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_TRIG = CW'((STARVE_LIMIT == 0) ? 0 : STARVE_LIMIT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      STEAL = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_nx;
   logic          pipe_act;
   logic          ld_rd_gnt;

   // Handshake: the loader holds ld_req/ld_we/ld_addr/ld_wdata stable until ld_gnt is
   // sampled high; the access happens in the ld_gnt cycle, read data follows with ld_rvalid.
   assign pipe_act   = pipe_mem_read | pipe_mem_write;
   assign pipe_rdata = mem_rdata;
   assign ld_rd_gnt  = ld_gnt & ~ld_we;
   assign state_dbg  = (state == STEAL);

   always_comb begin
      state_nx       = IDLE;
      wait_cnt_nx    = '0;
      ld_gnt         = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_load_type  = pipe_load_type;
      mem_store_type = pipe_store_type;
      mem_addr       = pipe_addr;
      mem_wdata      = pipe_wdata;
      case (state)
         IDLE: begin
            if (pipe_act) begin
               mem_read  = pipe_mem_read;
               mem_write = pipe_mem_write;
               if (ld_req) begin
                  wait_cnt_nx = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
                  if ((STARVE_LIMIT != 0) && (wait_cnt == CNT_TRIG)) begin
                     state_nx = STEAL;
                  end
               end
            end else if (ld_req) begin
               ld_gnt         = 1'b1;
               mem_read       = ~ld_we;
               mem_write      = ld_we;
               mem_load_type  = LD_LOAD_TYPE;
               mem_store_type = LD_STORE_TYPE;
               mem_addr       = ld_addr;
               mem_wdata      = ld_wdata;
            end
         end
         STEAL: begin
            // Pipeline strobes are masked; a dropped ld_req makes this an empty cycle.
            ld_gnt         = ld_req;
            mem_read       = ld_req & ~ld_we;
            mem_write      = ld_req & ld_we;
            mem_load_type  = LD_LOAD_TYPE;
            mem_store_type = LD_STORE_TYPE;
            mem_addr       = ld_addr;
            mem_wdata      = ld_wdata;
         end
      endcase
      if (rst) begin
         ld_gnt    = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         pipe_stall <= 1'b0;
         ld_rvalid  <= 1'b0;
         ld_rdata   <= '0;
      end else begin
         state      <= state_nx;
         wait_cnt   <= wait_cnt_nx;
         pipe_stall <= (state_nx == STEAL);
         ld_rvalid  <= ld_rd_gnt;
         if (ld_rd_gnt) begin
            ld_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (STARVE_LIMIT 4 and 0) on shared inputs, each with a
// word memory stub, compared every cycle against a cycle-level behavioural model, plus directed literals.
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic init_mem;
   always #5 clk = ~clk;

   logic        pipe_mem_read, pipe_mem_write;
   logic [2:0]  pipe_load_type;
   logic [1:0]  pipe_store_type;
   logic [9:0]  pipe_addr;
   logic [31:0] pipe_wdata;
   logic        ld_req, ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_wdata;

   logic [1:0][31:0] pipe_rdata_w, ld_rdata_w, mem_wdata_w, mem_rdata_w;
   logic [1:0]       pipe_stall_w, ld_gnt_w, ld_rvalid_w, mem_read_w, mem_write_w, state_dbg_w;
   logic [1:0][2:0]  mem_load_type_w;
   logic [1:0][1:0]  mem_store_type_w;
   logic [1:0][9:0]  mem_addr_w;

   logic [31:0] mem_st  [2][256];
   logic [31:0] mdl_mem [2][256];
   int          lim [2] = '{4, 0};
   int          run [2];
   bit          steal [2];
   bit          e_rvalid [2];
   logic [31:0] e_rdata [2];
   bit          ld_done;

   int n_pass  = 0;
   int n_total = 0;

   dmem_port_arbiter #(.STARVE_LIMIT(4)) dut4 (
      .clk(clk), .rst(rst),
      .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
      .pipe_load_type(pipe_load_type), .pipe_store_type(pipe_store_type),
      .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
      .pipe_rdata(pipe_rdata_w[0]), .pipe_stall(pipe_stall_w[0]),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt_w[0]), .ld_rvalid(ld_rvalid_w[0]), .ld_rdata(ld_rdata_w[0]),
      .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]),
      .mem_load_type(mem_load_type_w[0]), .mem_store_type(mem_store_type_w[0]),
      .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]),
      .state_dbg(state_dbg_w[0])
   );

   dmem_port_arbiter #(.STARVE_LIMIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
      .pipe_load_type(pipe_load_type), .pipe_store_type(pipe_store_type),
      .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
      .pipe_rdata(pipe_rdata_w[1]), .pipe_stall(pipe_stall_w[1]),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt_w[1]), .ld_rvalid(ld_rvalid_w[1]), .ld_rdata(ld_rdata_w[1]),
      .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]),
      .mem_load_type(mem_load_type_w[1]), .mem_store_type(mem_store_type_w[1]),
      .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]),
      .state_dbg(state_dbg_w[1])
   );

   function automatic logic [31:0] pat(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Word-wide memory stubs with combinational read
   assign mem_rdata_w = {mem_st[1][mem_addr_w[1][9:2]], mem_st[0][mem_addr_w[0][9:2]]};

   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mem_st[k][i] <= pat(i);
      end else begin
         for (int k = 0; k < 2; k++)
            if (mem_write_w[k]) mem_st[k][mem_addr_w[k][9:2]] <= mem_wdata_w[k];
      end
   end

   // Who owns the port this cycle and what it must look like. own: 0 none, 1 pipe, 2 loader, 3 unchecked
   function automatic void exp_port(input int k, output logic gnt, output logic rd, output logic wr,
                                    output logic stl, output logic [2:0] lt, output logic [1:0] st,
                                    output logic [9:0] a, output logic [31:0] wd, output int own);
      gnt = 1'b0; rd = 1'b0; wr = 1'b0; stl = 1'b0;
      lt = pipe_load_type; st = pipe_store_type; a = pipe_addr; wd = pipe_wdata; own = 0;
      if (rst) begin
         own = 3;
      end else if (steal[k]) begin
         stl = 1'b1; own = 2;
         gnt = ld_req; rd = ld_req & ~ld_we; wr = ld_req & ld_we;
         lt = 3'b010; st = 2'b10; a = ld_addr; wd = ld_wdata;
      end else if (pipe_mem_read || pipe_mem_write) begin
         rd = pipe_mem_read; wr = pipe_mem_write; own = 1;
      end else if (ld_req) begin
         gnt = 1'b1; rd = ~ld_we; wr = ld_we; own = 2;
         lt = 3'b010; st = 2'b10; a = ld_addr; wd = ld_wdata;
      end
   endfunction

   // Model state advance: count consecutive blocked loader cycles, steal once the count hits the limit
   always @(posedge clk or posedge rst) begin
      logic g, rd, wr, stl;
      logic [2:0] lt;
      logic [1:0] st;
      logic [9:0] a;
      logic [31:0] wd;
      int own;
      if (init_mem && !rst) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mdl_mem[k][i] = pat(i);
      end
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            if (init_mem)
               for (int i = 0; i < 256; i++) mdl_mem[k][i] = pat(i);
            run[k] = 0; steal[k] = 1'b0; e_rvalid[k] = 1'b0; e_rdata[k] = '0;
            if (k == 0) ld_done = 1'b0;
         end else begin
            exp_port(k, g, rd, wr, stl, lt, st, a, wd, own);
            e_rvalid[k] = g & ~ld_we;
            if (e_rvalid[k]) e_rdata[k] = mdl_mem[k][ld_addr[9:2]];
            if (wr) mdl_mem[k][a[9:2]] = wd;
            if (steal[k]) begin
               steal[k] = 1'b0; run[k] = 0;
            end else if ((pipe_mem_read || pipe_mem_write) && ld_req) begin
               run[k]++;
               steal[k] = (lim[k] != 0) && (run[k] >= lim[k]);
            end else begin
               run[k] = 0;
            end
            if (k == 0) ld_done = g;
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, (k == 0) ? 4 : 0, act, exp, $time);
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic g, rd, wr, stl;
      logic [2:0] lt;
      logic [1:0] st;
      logic [9:0] a;
      logic [31:0] wd;
      int own;
      for (int k = 0; k < 2; k++) begin
         exp_port(k, g, rd, wr, stl, lt, st, a, wd, own);
         chk("pipe_stall", k, 32'(pipe_stall_w[k]), 32'(stl));
         chk("ld_gnt",     k, 32'(ld_gnt_w[k]),     32'(g));
         chk("mem_read",   k, 32'(mem_read_w[k]),   32'(rd));
         chk("mem_write",  k, 32'(mem_write_w[k]),  32'(wr));
         chk("ld_rvalid",  k, 32'(ld_rvalid_w[k]),  32'(e_rvalid[k]));
         chk("ld_rdata",   k, ld_rdata_w[k],        e_rdata[k]);
         chk("pipe_rdata", k, pipe_rdata_w[k],      mem_rdata_w[k]);
         chk("state_dbg",  k, 32'(state_dbg_w[k]),  32'(steal[k] && !rst));
         if (own == 1 || own == 2) begin
            chk("mem_load_type",  k, 32'(mem_load_type_w[k]),  32'(lt));
            chk("mem_store_type", k, 32'(mem_store_type_w[k]), 32'(st));
         end
         if (own != 3) begin
            chk("mem_addr",  k, 32'(mem_addr_w[k]), 32'(a));
            chk("mem_wdata", k, mem_wdata_w[k],     wd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      pipe_mem_read = 1'b0; pipe_mem_write = 1'b0; pipe_load_type = 3'b010; pipe_store_type = 2'b10;
      pipe_addr = '0; pipe_wdata = '0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
   endtask

   initial begin
      rst = 1'b1; init_mem = 1'b1;
      idle_in();
      @(negedge clk);
      chk("reset stall",  0, 32'(pipe_stall_w[0]), 32'd0);
      chk("reset gnt",    0, 32'(ld_gnt_w[0]),     32'd0);
      chk("reset rvalid", 0, 32'(ld_rvalid_w[0]),  32'd0);
      chk("reset rdata",  0, ld_rdata_w[0],        32'd0);
      tick();
      rst = 1'b0; init_mem = 1'b0;

      // Loader write then read-back with the pipeline idle
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h010; ld_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1 gnt", 0, 32'(ld_gnt_w[0]), 32'd1);
      chk("t1 write", 0, 32'(mem_write_w[0]), 32'd1);
      chk("t1 store_type", 0, 32'(mem_store_type_w[0]), 32'd2);
      tick();
      ld_we = 1'b0;
      @(negedge clk);
      chk("t1 rd gnt", 1, 32'(ld_gnt_w[1]), 32'd1);
      tick();
      idle_in();
      @(negedge clk);
      chk("t1 rvalid", 0, 32'(ld_rvalid_w[0]), 32'd1);
      chk("t1 rdata", 0, ld_rdata_w[0], 32'hDEAD_BEEF);
      tick();

      // Starvation steal after four blocked cycles
      pipe_mem_read = 1'b1; pipe_addr = 10'h040;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h010;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t2 blocked gnt", 0, 32'(ld_gnt_w[0]), 32'd0);
         chk("t2 blocked stall", 0, 32'(pipe_stall_w[0]), 32'd0);
         tick();
      end
      @(negedge clk);
      chk("t2 steal stall", 0, 32'(pipe_stall_w[0]), 32'd1);
      chk("t2 steal gnt", 0, 32'(ld_gnt_w[0]), 32'd1);
      chk("t2 steal addr", 0, 32'(mem_addr_w[0]), 32'h010);
      chk("t2 nosteal gnt", 1, 32'(ld_gnt_w[1]), 32'd0);
      tick();
      ld_req = 1'b0;
      @(negedge clk);
      chk("t2 after stall", 0, 32'(pipe_stall_w[0]), 32'd0);
      chk("t2 rvalid", 0, 32'(ld_rvalid_w[0]), 32'd1);
      chk("t2 rdata", 0, ld_rdata_w[0], 32'hDEAD_BEEF);
      tick();

      // STARVE_LIMIT=0 never steals
      ld_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("t3 stall", 1, 32'(pipe_stall_w[1]), 32'd0);
         chk("t3 gnt", 1, 32'(ld_gnt_w[1]), 32'd0);
         tick();
      end
      pipe_mem_read = 1'b0;
      @(negedge clk);
      chk("t3 idle gnt", 1, 32'(ld_gnt_w[1]), 32'd1);
      tick();
      idle_in();
      tick();

      // Pipeline byte load passes its type and address through
      pipe_mem_read = 1'b1; pipe_load_type = 3'b000; pipe_addr = 10'h003;
      ld_req = 1'b1; ld_addr = 10'h030;
      @(negedge clk);
      chk("t4 load_type", 1, 32'(mem_load_type_w[1]), 32'd0);
      chk("t4 addr", 1, 32'(mem_addr_w[1]), 32'h003);
      chk("t4 gnt", 1, 32'(ld_gnt_w[1]), 32'd0);
      chk("t4 pipe_rdata", 1, pipe_rdata_w[1], pat(0));
      tick();
      idle_in();
      tick();

      // Same-cycle pipeline store and loader read of the same word
      pipe_mem_write = 1'b1; pipe_addr = 10'h020; pipe_wdata = 32'h1234_5678;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h020;
      @(negedge clk);
      chk("t5 gnt", 0, 32'(ld_gnt_w[0]), 32'd0);
      chk("t5 pipe write", 0, 32'(mem_write_w[0]), 32'd1);
      tick();
      pipe_mem_write = 1'b0;
      @(negedge clk);
      chk("t5 later gnt", 0, 32'(ld_gnt_w[0]), 32'd1);
      tick();
      ld_req = 1'b0;
      @(negedge clk);
      chk("t5 rvalid", 1, 32'(ld_rvalid_w[1]), 32'd1);
      chk("t5 rdata", 0, ld_rdata_w[0], 32'h1234_5678);
      tick();

      // Reset in the middle of a steal cycle
      pipe_mem_read = 1'b1; pipe_addr = 10'h044;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h020;
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      chk("t6 steal stall", 0, 32'(pipe_stall_w[0]), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t6 rst stall", 0, 32'(pipe_stall_w[0]), 32'd0);
      chk("t6 rst gnt", 0, 32'(ld_gnt_w[0]), 32'd0);
      chk("t6 rst read", 0, 32'(mem_read_w[0]), 32'd0);
      tick();
      rst = 1'b0; pipe_mem_read = 1'b0;
      @(negedge clk);
      chk("t6 release gnt", 0, 32'(ld_gnt_w[0]), 32'd1);
      chk("t6 no rvalid", 0, 32'(ld_rvalid_w[0]), 32'd0);
      tick();
      ld_req = 1'b0;
      @(negedge clk);
      chk("t6 rvalid", 0, 32'(ld_rvalid_w[0]), 32'd1);
      chk("t6 rdata", 0, ld_rdata_w[0], 32'h1234_5678);
      tick();

      // Randomized traffic; the loader holds each request until the model grants it
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = int'($urandom_range(0, 9));
         pipe_mem_read  = (r < 4) || (r == 9);
         pipe_mem_write = (r >= 4 && r < 7) || (r == 9);
         pipe_load_type  = 3'($urandom_range(0, 7));
         pipe_store_type = 2'($urandom_range(0, 3));
         pipe_addr  = 10'($urandom_range(0, 127));
         pipe_wdata = $urandom;
         if (!ld_req || ld_done) begin
            ld_req   = ($urandom_range(0, 2) != 0);
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 10'($urandom_range(0, 31) * 4);
            ld_wdata = $urandom;
         end
         tick();
      end
      idle_in();
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
